ifm_fifo_ctrl: RTL and testbench

IFM_FIFO_CTRL -- requirements
Module: ifm_fifo_ctrl

---
 rtl/ifm_fifo_ctrl_pkg.sv | 36 +++
 rtl/ifm_bank_flags.sv | 38 +++
 rtl/ifm_fifo_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_ifm_fifo_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_fifo_ctrl_pkg.sv
// Shared types and widths for the two-bank IFM FIFO controller.
package ifm_fifo_ctrl_pkg;

  localparam int TILE_LEN_W        = 13;
  localparam int NUM_TILES_W       = 16;
  localparam int REUSE_W           = 8;
  localparam int DEFAULT_FIFO_SIZE = 4608;

  typedef enum logic [2:0] {
    W_IDLE,
    W_CLR,
    W_FILL,
    W_WAIT,
    W_DONE
  } wr_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_WAIT,
    R_CLR,
    R_READ,
    R_DONE
  } rd_state_t;

  // A zero-length tile is treated as one word; no tile may exceed a bank.
  function automatic logic [TILE_LEN_W-1:0] clamp_tile_len(
    input logic [TILE_LEN_W-1:0] len,
    input logic [TILE_LEN_W-1:0] max_len
  );
    logic [TILE_LEN_W-1:0] v;
    v = (len == '0) ? TILE_LEN_W'(1) : len;
    if (v > max_len) v = max_len;
    return v;
  endfunction

endpackage

// File: rtl/ifm_bank_flags.sv
// Full flags for the two IFM banks: the writer sets a flag when a tile is
// complete, the reader clears it once all reuse passes are finished.
module ifm_bank_flags (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic [1:0] i_set,
  input  logic [1:0] i_clr,
  output logic [1:0] o_full
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flag
      logic r_full;

      // Per-bank flag; a clear (or job flush) wins over a set.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_full <= 1'b0;
        end else if (i_flush || i_clr[gi]) begin
          r_full <= 1'b0;
        end else if (i_set[gi]) begin
          r_full <= 1'b1;
        end
      end

      // The writer only finishes an empty bank and the reader only releases a
      // full one, so both hitting the same flag at once indicates a bug.
      always_ff @(posedge clk) begin
        if (!rst) assert (!(i_set[gi] && i_clr[gi]));
      end

      assign o_full[gi] = r_full;
    end
  endgenerate

endmodule

// File: rtl/ifm_fifo_ctrl.sv
// Ping-pong controller for a two-bank IFM FIFO: a writer FSM fills one bank
// while a reader FSM replays the other bank reuse_cnt times.
module ifm_fifo_ctrl
  import ifm_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int MAX_WGT_FIFO_SIZE = DEFAULT_FIFO_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TILE_LEN_W-1:0]  tile_len,
  input  logic [NUM_TILES_W-1:0] num_tiles,
  input  logic [REUSE_W-1:0]     reuse_cnt,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   rd_req,
  output logic                   out_valid,
  output logic                   rd_clr_1,
  output logic                   wr_clr_1,
  output logic                   rd_en_1,
  output logic                   wr_en_1,
  output logic                   rd_clr_2,
  output logic                   wr_clr_2,
  output logic                   rd_en_2,
  output logic                   wr_en_2,
  output logic                   ifm_demux,
  output logic                   ifm_mux,
  output logic                   busy,
  output logic                   done
);

  localparam logic [TILE_LEN_W-1:0] LP_MAX_LEN =
    (MAX_WGT_FIFO_SIZE >= (1 << TILE_LEN_W)) ? '1 : TILE_LEN_W'(MAX_WGT_FIFO_SIZE);

  generate
    if (DATA_WIDTH < 1 || MAX_WGT_FIFO_SIZE < 1) begin : g_bad_param
      $error("ifm_fifo_ctrl: DATA_WIDTH and MAX_WGT_FIFO_SIZE must be positive");
    end
  endgenerate

  // Latched job configuration and job status.
  logic [TILE_LEN_W-1:0]  r_tile_len;
  logic [NUM_TILES_W-1:0] r_num_tiles;
  logic [REUSE_W-1:0]     r_reuse;
  logic                   r_busy;

  // Writer side.
  wr_state_t              r_wr_state, w_wr_state_next;
  logic                   r_demux;
  logic [TILE_LEN_W-1:0]  r_wr_cnt;
  logic [NUM_TILES_W-1:0] r_tiles_written;
  logic                   w_wr_clr, w_in_ready, w_wr_accept, w_wr_last;

  // Reader side.
  rd_state_t              r_rd_state, w_rd_state_next;
  logic                   r_mux;
  logic [TILE_LEN_W-1:0]  r_rd_cnt;
  logic [REUSE_W-1:0]     r_pass;
  logic [NUM_TILES_W-1:0] r_tiles_read;
  logic                   w_rd_clr, w_rd_en, w_rd_pass_done, w_rd_tile_done;
  logic                   r_out_valid;

  logic                   w_start_ok, w_done;
  logic [1:0]             w_full, w_full_set, w_full_clr;

  assign w_start_ok = start && !r_busy;
  assign w_done     = r_busy && (r_wr_state == W_DONE) && (r_rd_state == R_DONE);

  ifm_bank_flags u_flags (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_start_ok),
    .i_set   (w_full_set),
    .i_clr   (w_full_clr),
    .o_full  (w_full)
  );

  // Config latch on an accepted start; busy spans start+1 through done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tile_len  <= '0;
      r_num_tiles <= '0;
      r_reuse     <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_tile_len  <= clamp_tile_len(tile_len, LP_MAX_LEN);
        r_num_tiles <= num_tiles;
        r_reuse     <= (reuse_cnt == '0) ? REUSE_W'(1) : reuse_cnt;
      end
      if (w_start_ok) r_busy <= 1'b1;
      else if (w_done) r_busy <= 1'b0;
    end
  end

  // Writer next-state: clear bank, fill tile_len words, then move on.
  always_comb begin
    w_wr_state_next = r_wr_state;
    w_wr_clr        = 1'b0;
    w_in_ready      = 1'b0;
    w_wr_last       = 1'b0;
    w_full_set      = 2'b00;
    case (r_wr_state)
      W_IDLE: if (w_start_ok) w_wr_state_next = (num_tiles == '0) ? W_DONE : W_CLR;
      W_CLR: begin
        w_wr_clr        = 1'b1;
        w_wr_state_next = W_FILL;
      end
      W_FILL: begin
        w_in_ready = 1'b1;
        if (in_valid && (r_wr_cnt == r_tile_len - TILE_LEN_W'(1))) begin
          w_wr_last           = 1'b1;
          w_full_set[r_demux] = 1'b1;
          if (r_tiles_written == r_num_tiles - NUM_TILES_W'(1)) w_wr_state_next = W_DONE;
          else if (w_full[~r_demux])                             w_wr_state_next = W_WAIT;
          else                                                   w_wr_state_next = W_CLR;
        end
      end
      W_WAIT: if (!w_full[r_demux]) w_wr_state_next = W_CLR;
      W_DONE: if (w_done) w_wr_state_next = W_IDLE;
      default: w_wr_state_next = W_IDLE;
    endcase
  end

  assign w_wr_accept = w_in_ready && in_valid;

  // Writer state, word counter, bank select and tile count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state      <= W_IDLE;
      r_demux         <= 1'b0;
      r_wr_cnt        <= '0;
      r_tiles_written <= '0;
    end else begin
      r_wr_state <= w_wr_state_next;
      if (r_wr_state == W_CLR) r_wr_cnt <= '0;
      else if (w_wr_accept)   r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_start_ok) begin
        r_demux         <= 1'b0;
        r_tiles_written <= '0;
      end else if (w_wr_last) begin
        r_demux         <= ~r_demux;
        r_tiles_written <= r_tiles_written + 1'b1;
      end
    end
  end

  // Reader next-state: wait for a full bank, rewind, replay reuse passes.
  always_comb begin
    w_rd_state_next = r_rd_state;
    w_rd_clr        = 1'b0;
    w_rd_en         = 1'b0;
    w_rd_pass_done  = 1'b0;
    w_rd_tile_done  = 1'b0;
    w_full_clr      = 2'b00;
    case (r_rd_state)
      R_IDLE: if (w_start_ok) w_rd_state_next = (num_tiles == '0) ? R_DONE : R_WAIT;
      R_WAIT: if (w_full[r_mux]) w_rd_state_next = R_CLR;
      R_CLR: begin
        w_rd_clr        = 1'b1;
        w_rd_state_next = R_READ;
      end
      R_READ: begin
        w_rd_en = rd_req;
        if (rd_req && (r_rd_cnt == r_tile_len - TILE_LEN_W'(1))) begin
          w_rd_pass_done = 1'b1;
          if (r_pass == r_reuse - REUSE_W'(1)) begin
            w_rd_tile_done    = 1'b1;
            w_full_clr[r_mux] = 1'b1;
            if (r_tiles_read == r_num_tiles - NUM_TILES_W'(1)) w_rd_state_next = R_DONE;
            else                                                w_rd_state_next = R_WAIT;
          end else begin
            w_rd_state_next = R_CLR;
          end
        end
      end
      R_DONE: if (w_done) w_rd_state_next = R_IDLE;
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  // Reader state, word/pass counters, bank select and tile count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state   <= R_IDLE;
      r_mux        <= 1'b0;
      r_rd_cnt     <= '0;
      r_pass       <= '0;
      r_tiles_read <= '0;
    end else begin
      r_rd_state <= w_rd_state_next;
      if (r_rd_state == R_CLR) r_rd_cnt <= '0;
      else if (w_rd_en)        r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_start_ok || w_rd_tile_done) r_pass <= '0;
      else if (w_rd_pass_done)          r_pass <= r_pass + 1'b1;
      if (w_start_ok) begin
        r_mux        <= 1'b0;
        r_tiles_read <= '0;
      end else if (w_rd_tile_done) begin
        r_mux        <= ~r_mux;
        r_tiles_read <= r_tiles_read + 1'b1;
      end
    end
  end

  // Bank read data appears one cycle after the read enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out_valid <= 1'b0;
    else     r_out_valid <= w_rd_en;
  end

  // Writing and reading the same bank together would corrupt the tile.
  always_ff @(posedge clk) begin
    if (!rst) assert (!((wr_en_1 && rd_en_1) || (wr_en_2 && rd_en_2)));
  end

  assign in_ready  = w_in_ready;
  assign wr_clr_1  = w_wr_clr && !r_demux;
  assign wr_clr_2  = w_wr_clr &&  r_demux;
  assign wr_en_1   = w_wr_accept && !r_demux;
  assign wr_en_2   = w_wr_accept &&  r_demux;
  assign rd_clr_1  = w_rd_clr && !r_mux;
  assign rd_clr_2  = w_rd_clr &&  r_mux;
  assign rd_en_1   = w_rd_en && !r_mux;
  assign rd_en_2   = w_rd_en &&  r_mux;
  assign ifm_demux = r_demux;
  assign ifm_mux   = r_mux;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = w_done;

endmodule

// File: tb/tb_ifm_fifo_ctrl.sv
// Scoreboard bench: each job pushes its expected bank events into queues,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_ifm_fifo_ctrl;

  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] tile_len = '0;
  logic [15:0] num_tiles = '0;
  logic [7:0]  reuse_cnt = '0;
  logic        in_valid = 1'b0;
  logic        rd_req = 1'b0;
  logic        in_ready, out_valid;
  logic        rd_clr_1, wr_clr_1, rd_en_1, wr_en_1;
  logic        rd_clr_2, wr_clr_2, rd_en_2, wr_en_2;
  logic        ifm_demux, ifm_mux, busy, done;

  ifm_fifo_ctrl #(.DATA_WIDTH(16), .MAX_WGT_FIFO_SIZE(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_len(tile_len),
    .num_tiles(num_tiles), .reuse_cnt(reuse_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .rd_req(rd_req),
    .out_valid(out_valid),
    .rd_clr_1(rd_clr_1), .wr_clr_1(wr_clr_1), .rd_en_1(rd_en_1), .wr_en_1(wr_en_1),
    .rd_clr_2(rd_clr_2), .wr_clr_2(wr_clr_2), .rd_en_2(rd_en_2), .wr_en_2(wr_en_2),
    .ifm_demux(ifm_demux), .ifm_mux(ifm_mux), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bank;
    int tile;
    bit last;
  } ev_t;

  ev_t q_wr[$];
  ev_t q_rd[$];
  ev_t q_wclr[$];
  ev_t q_rclr[$];

  int n_checks = 0;
  int n_errors = 0;
  int wr_obs, rd_obs, ov_obs, wt_done, rt_done;
  int done_seen = 0;
  int done_base = 0;
  bit overlap_seen;
  bit prev_rd = 1'b0;
  int iv_pct = 100;
  int rr_pct = 100;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bank_of(input logic b1, input logic b2);
    return b1 ? (b2 ? 3 : 1) : (b2 ? 2 : 0);
  endfunction

  function automatic int eff_len(input int len);
    return (len == 0) ? 1 : ((len > MAXW) ? MAXW : len);
  endfunction

  function automatic int eff_reuse(input int reuse);
    return (reuse == 0) ? 1 : reuse;
  endfunction

  // Reference model: tile t lives in bank 1 when t is even, bank 2 when odd;
  // each tile is written once and read reuse times, each pass after a rewind.
  task automatic build_expect(input int len, input int nt, input int reuse);
    int l, r, bank;
    l = eff_len(len);
    r = eff_reuse(reuse);
    for (int t = 0; t < nt; t++) begin
      bank = (t % 2) + 1;
      q_wclr.push_back('{bank, t, 1'b1});
      for (int w = 0; w < l; w++) q_wr.push_back('{bank, t, (w == l - 1)});
      for (int p = 0; p < r; p++) begin
        q_rclr.push_back('{bank, t, (p == r - 1)});
        for (int w = 0; w < l; w++) q_rd.push_back('{bank, t, (p == r - 1) && (w == l - 1)});
      end
    end
  endtask

  task automatic flush_queues();
    q_wr.delete();
    q_rd.delete();
    q_wclr.delete();
    q_rclr.delete();
  endtask

  // Random producer/consumer handshake, re-drawn every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(99) < iv_pct);
      rd_req   = ($urandom_range(99) < rr_pct);
    end
  end

  // Monitor: compare every observed bank event against the queued expectation.
  always @(negedge clk) begin
    ev_t e;
    int  b, wt0, rt0;
    if (rst) begin
      prev_rd = 1'b0;
    end else begin
      wt0 = wt_done;
      rt0 = rt_done;
      b = bank_of(rd_en_1, rd_en_2);
      if (b != 0) begin
        if (q_rd.size() == 0) check("rd_unexpected", b, 0);
        else begin
          e = q_rd.pop_front();
          check("rd_bank", b, e.bank);
          check("rd_after_fill", int'(e.tile < wt0), 1);
          rd_obs++;
          if (e.last) rt_done++;
        end
      end
      b = bank_of(wr_en_1, wr_en_2);
      if (b != 0) begin
        if (q_wr.size() == 0) check("wr_unexpected", b, 0);
        else begin
          e = q_wr.pop_front();
          check("wr_bank", b, e.bank);
          check("wr_ahead_limit", int'(e.tile < rt0 + 2), 1);
          wr_obs++;
          if (e.last) wt_done++;
        end
      end
      b = bank_of(wr_clr_1, wr_clr_2);
      if (b != 0) begin
        if (q_wclr.size() == 0) check("wr_clr_unexpected", b, 0);
        else begin
          e = q_wclr.pop_front();
          check("wr_clr_bank", b, e.bank);
        end
      end
      b = bank_of(rd_clr_1, rd_clr_2);
      if (b != 0) begin
        if (q_rclr.size() == 0) check("rd_clr_unexpected", b, 0);
        else begin
          e = q_rclr.pop_front();
          check("rd_clr_bank", b, e.bank);
        end
      end
      check("out_valid_latency", int'(out_valid), int'(prev_rd));
      if (out_valid) ov_obs++;
      prev_rd = rd_en_1 | rd_en_2;
      check("bank_conflict", int'((wr_en_1 & rd_en_1) | (wr_en_2 & rd_en_2)), 0);
      if (wr_en_2 && rd_en_1) overlap_seen = 1'b1;
      if (done) done_seen++;
    end
  end

  task automatic check_all_zero(input string name);
    check(name, int'({in_ready, out_valid, rd_clr_1, wr_clr_1, rd_en_1, wr_en_1,
                      rd_clr_2, wr_clr_2, rd_en_2, wr_en_2, ifm_demux, ifm_mux,
                      busy, done}), 0);
  endtask

  task automatic start_job(input int len, input int nt, input int reuse);
    wr_obs = 0; rd_obs = 0; ov_obs = 0; wt_done = 0; rt_done = 0;
    overlap_seen = 1'b0;
    done_base = done_seen;
    build_expect(len, nt, reuse);
    tile_len  = len[12:0];
    num_tiles = nt[15:0];
    reuse_cnt = reuse[7:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_job(input int len, input int nt, input int reuse);
    int budget, l, r;
    l = eff_len(len);
    r = eff_reuse(reuse);
    budget = 0;
    while (done_seen == done_base && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    check("done_timeout", int'(done_seen != done_base), 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_seen - done_base, 1);
    check("busy_after_done", int'(busy), 0);
    check("wr_left", q_wr.size(), 0);
    check("rd_left", q_rd.size(), 0);
    check("wr_clr_left", q_wclr.size(), 0);
    check("rd_clr_left", q_rclr.size(), 0);
    check("wr_words", wr_obs, nt * l);
    check("rd_words", rd_obs, nt * l * r);
    check("out_valid_words", ov_obs, nt * l * r);
    $display("job len=%0d tiles=%0d reuse=%0d wr=%0d rd=%0d ov=%0d",
             len, nt, reuse, wr_obs, rd_obs, ov_obs);
    if (done_seen == done_base) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    flush_queues();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget, d0, len, nt, reuse;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("idle_outputs");

    // Basic single tile.
    iv_pct = 100; rr_pct = 100;
    start_job(4, 1, 1);
    check("busy_after_start", int'(busy), 1);
    finish_job(4, 1, 1);

    // Ping-pong over three tiles, with a start pulse mid-job that must be ignored.
    start_job(8, 3, 1);
    repeat (5) @(posedge clk);
    #1;
    tile_len = 13'd2; num_tiles = 16'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_job(8, 3, 1);
    check("pingpong_overlap", int'(overlap_seen), 1);

    // Reuse passes.
    start_job(5, 2, 3);
    finish_job(5, 2, 3);

    // Back-pressure: no reads, writer must stall after filling both banks.
    rr_pct = 0;
    start_job(4, 3, 1);
    repeat (30) @(posedge clk);
    #1;
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_words", wr_obs, 8);
    check("bp_reads", rd_obs, 0);
    check("bp_demux", int'(ifm_demux), 0);
    rr_pct = 100;
    finish_job(4, 3, 1);

    // Corners: zero tiles, zero length, oversize length, zero reuse.
    start_job(3, 0, 2);
    check("zero_tiles_done", int'(done), 1);
    check("zero_tiles_busy", int'(busy), 1);
    finish_job(3, 0, 2);
    start_job(0, 2, 1);
    finish_job(0, 2, 1);
    start_job(40, 1, 1);
    finish_job(40, 1, 1);
    start_job(3, 2, 0);
    finish_job(3, 2, 0);

    // Reset after three words of an eight-word tile.
    start_job(8, 2, 1);
    budget = 0;
    while (wr_obs < 3 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    check("midfill_reached", int'(wr_obs >= 3), 1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("reset_midjob");
    d0 = done_seen;
    flush_queues();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_reset", done_seen - d0, 0);
    check_all_zero("idle_after_reset");
    start_job(8, 2, 1);
    finish_job(8, 2, 1);

    // Randomized jobs.
    for (int i = 0; i < 8; i++) begin
      len    = $urandom_range(1, 12);
      nt     = $urandom_range(0, 5);
      reuse  = $urandom_range(1, 4);
      iv_pct = $urandom_range(30, 100);
      rr_pct = $urandom_range(30, 100);
      start_job(len, nt, reuse);
      finish_job(len, nt, reuse);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
